plugboard_table: RTL and testbench
==================================

Name: plugboard_table

Overview:
- Programmable Enigma plugboard (Steckerbrett) with storage for up to MAX_PAIRS letter swaps.
- Letters are one-hot, ALPHABET bits wide; bit 0 = A.
- Pairs are loaded over a two-letter valid/ready programming handshake.
- Sits on both sides of the rotor/reflector core, one instance per side; registered lookup with 1-cycle latency.

Parameters:
- ALPHABET, 26, letter width (one-hot bits).
- MAX_PAIRS, 10, number of pair slots.
- CNT_W, $clog2(MAX_PAIRS+1), width of pair_count.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; empties the table.
- prog_valid  in  1  prog_letter is valid this cycle.
- prog_ready  out  1  block accepts a programming letter.
- prog_letter  in  ALPHABET  one-hot letter being programmed.
- prog_error  out  1  one-cycle pulse; the last programming letter was rejected.
- in_valid  in  1  lookup request.
- in  in  ALPHABET  one-hot letter to translate.
- out_valid  out  1  out holds a translation.
- out  out  ALPHABET  translated letter.
- pair_count  out  CNT_W  number of occupied slots.

Behaviour:
- Reset values: out=0, out_valid=0, prog_error=0, pair_count=0, all slots invalid, FSM=WAIT_FIRST, first-letter register=0.
- prog_ready = (FSM==WAIT_SECOND) or (pair_count<MAX_PAIRS). It is combinational from state.
- A programming letter is accepted on a cycle with prog_valid && prog_ready && !clear.
- FSM WAIT_FIRST, on accept:
  - If the letter is exactly one-hot and not plugged: latch it, go to WAIT_SECOND.
  - Otherwise: pulse prog_error and stay in WAIT_FIRST.
- FSM WAIT_SECOND, on accept:
  - If the letter is exactly one-hot, not plugged, and differs from the latched letter: write {first, second} into the lowest-index invalid slot, set it valid, increment pair_count, go to WAIT_FIRST.
  - Otherwise: pulse prog_error, discard the latched letter, go to WAIT_FIRST.
- "Plugged" means the letter is in the OR of all valid slot letters.
- Lookup:
  - The cycle after in_valid, out_valid=1.
  - If in equals slot.a of a valid slot, out=slot.b; if it equals slot.b, out=slot.a; otherwise out=in.
  - Inputs that are not one-hot (including 0) pass through unchanged.
  - With in_valid=0, out_valid=0 next cycle and out holds its last value.
- Throughput: one lookup per cycle, fully pipelined, no backpressure.
- Same-cycle lookup and pair commit: the lookup uses the table as it was before the commit. The new pair is visible from the next cycle.
- clear: same-cycle priority over programming. Next cycle all slots are invalid, pair_count=0, FSM=WAIT_FIRST, and no prog_error is raised. A lookup in the clear cycle uses the old table.
- Full table: pair_count==MAX_PAIRS and WAIT_FIRST gives prog_ready=0. A letter offered then is not accepted and not flagged.
- Reset mid-programming: the latched first letter is lost and no partial pair is stored.
- Invariant: an involution, so applying the mapping twice returns the original letter. No letter appears in two slots.

Optional Feature:
- Macro: PLUGBOARD_UNPLUG_EN.
- Defined: in WAIT_FIRST, an accepted one-hot letter that is already plugged does the following:
  - invalidates the slot containing it;
  - decrements pair_count;
  - stays in WAIT_FIRST;
  - raises no prog_error.
  - prog_ready is then asserted in WAIT_FIRST even at full count, so that unplugging remains possible. An unplugged letter offered at full count is accepted and rejected with a prog_error pulse.
- Undefined: a plugged letter in WAIT_FIRST is rejected with prog_error. Slots can only be freed by clear or reset.

Decomposition:
- Package plugboard_pkg holds:
  - the ALPHABET default;
  - the slot struct typedef {valid, a, b};
  - FSM state enum WAIT_FIRST/WAIT_SECOND;
  - function is_onehot().
- One sub-module, plugboard_lookup: combinational slot-array search producing the swapped letter. The top level registers its output.

Test Plan:
- Reset, then program A(0x1), B(0x2) -> pair_count=1, no prog_error. Lookup in=0x1 -> out=0x2 next cycle; in=0x2 -> 0x1; in=C(0x4) -> 0x4.
- Program 10 disjoint pairs -> pair_count=10, prog_ready=0. Offer a new letter -> not accepted, no error, count still 10.
- Program A then A -> prog_error pulse, FSM back to WAIT_FIRST. Program prog_letter=0x3 -> prog_error. Lookup in=0 -> out=0.
- Lookup in=D in the same cycle that D–E commits -> out=D. Same lookup next cycle -> out=E.
- Load 3 pairs, assert clear together with prog_valid -> pair_count=0, no error, all lookups pass through.
- PLUGBOARD_UNPLUG_EN: A–B plugged, program A -> count decrements, lookup A -> A. Without the macro, the same stimulus -> prog_error and the mapping is kept.

Source files
------------

// File: rtl/plugboard_pkg.sv
// plugboard_pkg: shared types and helpers for the plugboard table.
//   ALPHABET_DEFAULT : one-hot letter width (bit 0 = A)
//   slot_t           : one pair slot {valid, a, b}
//   state_t          : programming FSM states
//   is_onehot()      : exactly-one-bit-set test for a letter
package plugboard_pkg;

  localparam int unsigned ALPHABET_DEFAULT = 26;

  typedef struct packed {
    logic                        valid;
    logic [ALPHABET_DEFAULT-1:0] a;
    logic [ALPHABET_DEFAULT-1:0] b;
  } slot_t;

  typedef enum logic {
    WAIT_FIRST,
    WAIT_SECOND
  } state_t;

  function automatic logic is_onehot(input logic [ALPHABET_DEFAULT-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/plugboard_if.sv
// plugboard_if: programming and lookup signals of the plugboard table.
//   clear        : synchronous table clear (master -> slave)
//   prog_valid/prog_ready/prog_letter : one-letter programming handshake
//   prog_error   : one-cycle reject pulse (slave -> master)
//   in_valid/in  : lookup request; out_valid/out : registered translation
//   pair_count   : number of occupied slots
interface plugboard_if #(
  parameter int unsigned ALPHABET = 26,
  parameter int unsigned CNT_W    = 4
);
  logic                clear;
  logic                prog_valid;
  logic                prog_ready;
  logic [ALPHABET-1:0] prog_letter;
  logic                prog_error;
  logic                in_valid;
  logic [ALPHABET-1:0] in;
  logic                out_valid;
  logic [ALPHABET-1:0] out;
  logic [CNT_W-1:0]    pair_count;

  modport master (
    output clear, prog_valid, prog_letter, in_valid, in,
    input  prog_ready, prog_error, out_valid, out, pair_count
  );

  modport slave (
    input  clear, prog_valid, prog_letter, in_valid, in,
    output prog_ready, prog_error, out_valid, out, pair_count
  );
endinterface

// File: rtl/plugboard_lookup.sv
// plugboard_lookup: combinational search of the slot array.
//   slots      : pair table (valid, a, b per slot)
//   letter_in  : one-hot letter to translate
//   letter_out : partner letter if plugged, otherwise letter_in unchanged
// Letters that are not exactly one-hot always pass through.
module plugboard_lookup
  import plugboard_pkg::*;
#(
  parameter int unsigned ALPHABET  = ALPHABET_DEFAULT,
  parameter int unsigned MAX_PAIRS = 10
) (
  input  slot_t [MAX_PAIRS-1:0] slots,
  input  logic  [ALPHABET-1:0]  letter_in,
  output logic  [ALPHABET-1:0]  letter_out
);

  // Slots are disjoint, so at most one slot can match.
  always_comb begin
    letter_out = letter_in;
    if (is_onehot(letter_in)) begin
      for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
        if (slots[i].valid) begin
          if (letter_in == slots[i].a)      letter_out = slots[i].b;
          else if (letter_in == slots[i].b) letter_out = slots[i].a;
        end
      end
    end
  end

endmodule

// File: rtl/plugboard_table.sv
// plugboard_table: programmable Enigma plugboard with MAX_PAIRS swap slots.
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : plugboard_if.slave (clear, programming handshake, lookup, pair_count)
// Lookup is registered (1-cycle latency) against the table as it was before
// any same-cycle commit or clear.
// Optional: define PLUGBOARD_UNPLUG_EN to let a plugged letter offered in
// WAIT_FIRST remove its pair instead of being rejected.
module plugboard_table
  import plugboard_pkg::*;
#(
  parameter int unsigned ALPHABET  = ALPHABET_DEFAULT,
  parameter int unsigned MAX_PAIRS = 10,
  parameter int unsigned CNT_W     = $clog2(MAX_PAIRS + 1)
) (
  input logic        CLOCK_50,
  input logic        reset,
  plugboard_if.slave bus
);

  state_t                state_q, state_d;
  logic [ALPHABET-1:0]   first_q, first_d;
  slot_t [MAX_PAIRS-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ALPHABET-1:0]   out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  prog_error_q, prog_error_d;

  logic [ALPHABET-1:0]   lookup_out;
  logic [ALPHABET-1:0]   plugged;
  logic                  full, accept, letter_ok, placed;

  plugboard_lookup #(
    .ALPHABET (ALPHABET),
    .MAX_PAIRS(MAX_PAIRS)
  ) u_lookup (
    .slots     (slots_q),
    .letter_in (bus.in),
    .letter_out(lookup_out)
  );

  always_comb begin
    plugged = '0;
    for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
      if (slots_q[i].valid) plugged = plugged | slots_q[i].a | slots_q[i].b;
    end
  end

  assign full = (count_q == CNT_W'(MAX_PAIRS));

`ifdef PLUGBOARD_UNPLUG_EN
  // WAIT_SECOND always has a free slot, and WAIT_FIRST must stay open for unplugging.
  assign bus.prog_ready = 1'b1;
`else
  assign bus.prog_ready = (state_q == WAIT_SECOND) || !full;
`endif

  assign accept    = bus.prog_valid && bus.prog_ready && !bus.clear;
  assign letter_ok = is_onehot(bus.prog_letter) && ((bus.prog_letter & plugged) == '0);

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    slots_d      = slots_q;
    count_d      = count_q;
    prog_error_d = 1'b0;
    placed       = 1'b0;
    out_valid_d  = bus.in_valid;
    out_d        = bus.in_valid ? lookup_out : out_q;

    if (bus.clear) begin
      state_d = WAIT_FIRST;
      first_d = '0;
      slots_d = '0;
      count_d = '0;
    end else if (accept) begin
      case (state_q)
        WAIT_FIRST: begin
          // The full check only matters when ready is forced high for unplugging.
          if (letter_ok && !full) begin
            first_d = bus.prog_letter;
            state_d = WAIT_SECOND;
          end
`ifdef PLUGBOARD_UNPLUG_EN
          else if (is_onehot(bus.prog_letter) && ((bus.prog_letter & plugged) != '0)) begin
            for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
              if (slots_q[i].valid &&
                  ((slots_q[i].a == bus.prog_letter) || (slots_q[i].b == bus.prog_letter)))
                slots_d[i].valid = 1'b0;
            end
            count_d = count_q - 1'b1;
          end
`endif
          else begin
            prog_error_d = 1'b1;
          end
        end
        WAIT_SECOND: begin
          if (letter_ok && (bus.prog_letter != first_q)) begin
            for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
              if (!placed && !slots_q[i].valid) begin
                slots_d[i] = '{valid: 1'b1, a: first_q, b: bus.prog_letter};
                placed     = 1'b1;
              end
            end
            count_d = count_q + 1'b1;
          end else begin
            prog_error_d = 1'b1;
          end
          state_d = WAIT_FIRST;
          first_d = '0;
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_FIRST;
      first_q      <= '0;
      slots_q      <= '0;
      count_q      <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      prog_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      slots_q      <= slots_d;
      count_q      <= count_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      prog_error_q <= prog_error_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.prog_error = prog_error_q;
  assign bus.pair_count = count_q;

endmodule

// File: tb/tb_plugboard_table.sv
// tb_plugboard_table: directed self-checking bench for plugboard_table.
// Honours PLUGBOARD_UNPLUG_EN for the unplug and full-table expectations.
module tb_plugboard_table;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  plugboard_if #(.ALPHABET(26), .CNT_W(4)) bus ();

  plugboard_table #(
    .ALPHABET (26),
    .MAX_PAIRS(10),
    .CNT_W    (4)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [25:0] l);
    bus.prog_valid  = 1'b1;
    bus.prog_letter = l;
    tick();
    bus.prog_valid  = 1'b0;
    bus.prog_letter = '0;
  endtask

  task automatic look(input logic [25:0] l);
    bus.in_valid = 1'b1;
    bus.in       = l;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.out !== 26'h0) begin errors++; $display("FAIL reset_out: got %h expected %h", bus.out, 26'h0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL reset_prog_error: got %b expected 0", bus.prog_error); end
    checks++; if (bus.pair_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.pair_count); end
    checks++; if (bus.prog_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.prog_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_pair();
    prog(26'h1);
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL basic_err_first: got %b expected 0", bus.prog_error); end
    prog(26'h2);
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL basic_err_second: got %b expected 0", bus.prog_error); end
    checks++; if (bus.pair_count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", bus.pair_count); end
    look(26'h1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out !== 26'h2) begin errors++; $display("FAIL basic_a_to_b: got %h expected %h", bus.out, 26'h2); end
    look(26'h2);
    checks++; if (bus.out !== 26'h1) begin errors++; $display("FAIL basic_b_to_a: got %h expected %h", bus.out, 26'h1); end
    look(26'h4);
    checks++; if (bus.out !== 26'h4) begin errors++; $display("FAIL basic_c_pass: got %h expected %h", bus.out, 26'h4); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out !== 26'h4) begin errors++; $display("FAIL basic_idle_hold: got %h expected %h", bus.out, 26'h4); end
  endtask

  task automatic test_full();
    logic [25:0] l;
    do_clear();
    checks++; if (bus.pair_count !== 4'd0) begin errors++; $display("FAIL full_pre_clear: got %0d expected 0", bus.pair_count); end
    for (int i = 0; i < 10; i++) begin
      l = 26'd1 << (2 * i);
      prog(l);
      l = 26'd1 << (2 * i + 1);
      prog(l);
    end
    checks++; if (bus.pair_count !== 4'd10) begin errors++; $display("FAIL full_count: got %0d expected 10", bus.pair_count); end
`ifdef PLUGBOARD_UNPLUG_EN
    checks++; if (bus.prog_ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b expected 1", bus.prog_ready); end
    prog(26'h100000);
    checks++; if (bus.prog_error !== 1'b1) begin errors++; $display("FAIL full_offer_err: got %b expected 1", bus.prog_error); end
`else
    checks++; if (bus.prog_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.prog_ready); end
    prog(26'h100000);
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL full_offer_err: got %b expected 0", bus.prog_error); end
`endif
    checks++; if (bus.pair_count !== 4'd10) begin errors++; $display("FAIL full_count_after: got %0d expected 10", bus.pair_count); end
    look(26'h80000);
    checks++; if (bus.out !== 26'h40000) begin errors++; $display("FAIL full_last_pair: got %h expected %h", bus.out, 26'h40000); end
    look(26'h100000);
    checks++; if (bus.out !== 26'h100000) begin errors++; $display("FAIL full_unplugged_pass: got %h expected %h", bus.out, 26'h100000); end
  endtask

  task automatic test_errors();
    do_clear();
    prog(26'h1);
    prog(26'h1);
    checks++; if (bus.prog_error !== 1'b1) begin errors++; $display("FAIL err_same_letter: got %b expected 1", bus.prog_error); end
    tick();
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b expected 0", bus.prog_error); end
    prog(26'h3);
    checks++; if (bus.prog_error !== 1'b1) begin errors++; $display("FAIL err_not_onehot: got %b expected 1", bus.prog_error); end
    prog(26'h4);
    prog(26'h8);
    checks++; if (bus.pair_count !== 4'd1) begin errors++; $display("FAIL err_recover_count: got %0d expected 1", bus.pair_count); end
    prog(26'h10);
    prog(26'h4);
    checks++; if (bus.prog_error !== 1'b1) begin errors++; $display("FAIL err_second_plugged: got %b expected 1", bus.prog_error); end
    checks++; if (bus.pair_count !== 4'd1) begin errors++; $display("FAIL err_count_kept: got %0d expected 1", bus.pair_count); end
    look(26'h0);
    checks++; if (bus.out !== 26'h0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL err_zero_lookup: got %h/%b expected 0/1", bus.out, bus.out_valid); end
    look(26'hC);
    checks++; if (bus.out !== 26'hC) begin errors++; $display("FAIL err_multi_hot_pass: got %h expected %h", bus.out, 26'hC); end
  endtask

  task automatic test_commit_collision();
    do_clear();
    prog(26'h8);
    bus.prog_valid  = 1'b1;
    bus.prog_letter = 26'h10;
    bus.in_valid    = 1'b1;
    bus.in          = 26'h8;
    tick();
    bus.prog_valid  = 1'b0;
    bus.in_valid    = 1'b0;
    checks++; if (bus.out !== 26'h8) begin errors++; $display("FAIL collide_old_table: got %h expected %h", bus.out, 26'h8); end
    checks++; if (bus.pair_count !== 4'd1) begin errors++; $display("FAIL collide_count: got %0d expected 1", bus.pair_count); end
    look(26'h8);
    checks++; if (bus.out !== 26'h10) begin errors++; $display("FAIL collide_new_table: got %h expected %h", bus.out, 26'h10); end
    look(26'h10);
    checks++; if (bus.out !== 26'h8) begin errors++; $display("FAIL collide_reverse: got %h expected %h", bus.out, 26'h8); end
  endtask

  task automatic test_clear();
    do_clear();
    prog(26'h1);  prog(26'h2);
    prog(26'h4);  prog(26'h8);
    prog(26'h10); prog(26'h20);
    checks++; if (bus.pair_count !== 4'd3) begin errors++; $display("FAIL clear_pre_count: got %0d expected 3", bus.pair_count); end
    bus.clear       = 1'b1;
    bus.prog_valid  = 1'b1;
    bus.prog_letter = 26'h40;
    bus.in_valid    = 1'b1;
    bus.in          = 26'h1;
    tick();
    bus.clear       = 1'b0;
    bus.prog_valid  = 1'b0;
    bus.in_valid    = 1'b0;
    checks++; if (bus.out !== 26'h2) begin errors++; $display("FAIL clear_lookup_old: got %h expected %h", bus.out, 26'h2); end
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL clear_no_err: got %b expected 0", bus.prog_error); end
    checks++; if (bus.pair_count !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", bus.pair_count); end
    look(26'h1);
    checks++; if (bus.out !== 26'h1) begin errors++; $display("FAIL clear_pass_a: got %h expected %h", bus.out, 26'h1); end
    look(26'h20);
    checks++; if (bus.out !== 26'h20) begin errors++; $display("FAIL clear_pass_f: got %h expected %h", bus.out, 26'h20); end
    prog(26'h40);
    prog(26'h80);
    checks++; if (bus.pair_count !== 4'd1 || bus.prog_error !== 1'b0) begin errors++; $display("FAIL clear_reprog: got count %0d err %b expected 1/0", bus.pair_count, bus.prog_error); end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.in = 26'h40;  tick();
    checks++; if (bus.out !== 26'h80) begin errors++; $display("FAIL b2b_0: got %h expected %h", bus.out, 26'h80); end
    bus.in = 26'h80;  tick();
    checks++; if (bus.out !== 26'h40) begin errors++; $display("FAIL b2b_1: got %h expected %h", bus.out, 26'h40); end
    bus.in = 26'h100; tick();
    checks++; if (bus.out !== 26'h100 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_2: got %h/%b expected %h/1", bus.out, bus.out_valid, 26'h100); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out !== 26'h100) begin errors++; $display("FAIL b2b_idle: got %h/%b expected %h/0", bus.out, bus.out_valid, 26'h100); end
  endtask

  task automatic test_unplug();
    do_clear();
    prog(26'h1);
    prog(26'h2);
    prog(26'h1);
`ifdef PLUGBOARD_UNPLUG_EN
    checks++; if (bus.prog_error !== 1'b0) begin errors++; $display("FAIL unplug_err: got %b expected 0", bus.prog_error); end
    checks++; if (bus.pair_count !== 4'd0) begin errors++; $display("FAIL unplug_count: got %0d expected 0", bus.pair_count); end
    look(26'h1);
    checks++; if (bus.out !== 26'h1) begin errors++; $display("FAIL unplug_lookup: got %h expected %h", bus.out, 26'h1); end
`else
    checks++; if (bus.prog_error !== 1'b1) begin errors++; $display("FAIL unplug_err: got %b expected 1", bus.prog_error); end
    checks++; if (bus.pair_count !== 4'd1) begin errors++; $display("FAIL unplug_count: got %0d expected 1", bus.pair_count); end
    look(26'h1);
    checks++; if (bus.out !== 26'h2) begin errors++; $display("FAIL unplug_lookup: got %h expected %h", bus.out, 26'h2); end
`endif
  endtask

  task automatic test_reset_mid();
    do_clear();
    prog(26'h1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    checks++; if (bus.pair_count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.pair_count); end
    prog(26'h4);
    prog(26'h8);
    checks++; if (bus.pair_count !== 4'd1 || bus.prog_error !== 1'b0) begin errors++; $display("FAIL midrst_new_pair: got count %0d err %b expected 1/0", bus.pair_count, bus.prog_error); end
    look(26'h1);
    checks++; if (bus.out !== 26'h1) begin errors++; $display("FAIL midrst_first_lost: got %h expected %h", bus.out, 26'h1); end
    look(26'h4);
    checks++; if (bus.out !== 26'h8) begin errors++; $display("FAIL midrst_lookup: got %h expected %h", bus.out, 26'h8); end
  endtask

  initial begin
    bus.clear       = 1'b0;
    bus.prog_valid  = 1'b0;
    bus.prog_letter = '0;
    bus.in_valid    = 1'b0;
    bus.in          = '0;
    test_reset();
    test_basic_pair();
    test_full();
    test_errors();
    test_commit_collision();
    test_clear();
    test_back_to_back();
    test_unplug();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
